// File: rtl/prg_monitor_if.sv
// Host byte link, byte transmitter and programmer-side memory port of prg_monitor.
// master = the monitor itself, slave = UART pair + CPU memory around it.
interface prg_monitor_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       prg_we;
    logic [7:0] prg_MA;
    logic [7:0] prg_WD;
    logic [7:0] prg_RD;
    logic       busy;
    logic       err_ovr;

    modport master (
        input  rx_data, rx_valid, tx_ready, prg_RD,
        output tx_data, tx_valid, prg_we, prg_MA, prg_WD, busy, err_ovr
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, prg_RD,
        input  tx_data, tx_valid, prg_we, prg_MA, prg_WD, busy, err_ovr
    );
endinterface

// File: rtl/prg_monitor.sv
// Binary command parser driving the CPU memory's programmer port (W/R/D/L commands)
// and replying through a byte transmitter handshake.
module prg_monitor #(
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic          clock,
    input  logic          reset,
    prg_monitor_if.master bus
);
    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_CNT, GET_DATA, WRITE, READ, SEND} state_t;
    typedef enum logic [1:0] {OP_W, OP_R, OP_D, OP_L} op_t;

    localparam int unsigned   TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    localparam logic [1:0]    LAT  = 2'(RD_LAT);
    localparam logic [7:0]    ACK  = 8'h06;
    localparam logic [7:0]    NAK  = 8'h15;

    state_t        state_q;
    op_t           op_q;
    logic [7:0]    addr_q;
    logic [8:0]    cnt_q;
    logic [1:0]    lat_q;
    logic [TW-1:0] tmr_q;
    logic          we_q;
    logic [7:0]    ma_q;
    logic [7:0]    wd_q;
    logic [7:0]    txd_q;
    logic          txv_q;
    logic          err_q;

    logic          get_st;
    logic          tmo;
    logic          hs;
    logic [8:0]    cnt_dec;
    logic [7:0]    addr_inc;

    assign get_st   = (state_q == GET_ADDR) || (state_q == GET_CNT) || (state_q == GET_DATA);
    assign tmo      = (TIMEOUT != 0) && get_st && !bus.rx_valid && (tmr_q == TMAX);
    assign hs       = txv_q && bus.tx_ready;
    assign cnt_dec  = cnt_q - 9'd1;
    assign addr_inc = addr_q + 8'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= OP_W;
            addr_q  <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
            tmr_q   <= '0;
            we_q    <= 1'b0;
            ma_q    <= '0;
            wd_q    <= '0;
            txd_q   <= '0;
            txv_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // Bytes arriving while the block is not listening are dropped.
            if (bus.rx_valid && (state_q == WRITE || state_q == READ || state_q == SEND))
                err_q <= 1'b1;

            if (bus.rx_valid || !get_st) tmr_q <= '0;
            else                         tmr_q <= tmr_q + 1'b1;

            // tmo implies no rx_valid, so the case below never fights this abort.
            if (tmo) begin
                state_q <= IDLE;
                err_q   <= 1'b1;
            end

            case (state_q)
                IDLE: if (bus.rx_valid) begin
                    state_q <= GET_ADDR;
                    case (bus.rx_data)
                        8'h57:   op_q <= OP_W;
                        8'h52:   op_q <= OP_R;
                        8'h44:   op_q <= OP_D;
                        8'h4C:   op_q <= OP_L;
                        default: begin
                            op_q    <= OP_W;
                            txd_q   <= NAK;
                            txv_q   <= 1'b1;
                            state_q <= SEND;
                        end
                    endcase
                end
                GET_ADDR: if (bus.rx_valid) begin
                    addr_q <= bus.rx_data;
                    cnt_q  <= 9'd1;
                    case (op_q)
                        OP_W:    state_q <= GET_DATA;
                        OP_R: begin
                            ma_q    <= bus.rx_data;
                            lat_q   <= '0;
                            state_q <= READ;
                        end
                        default: state_q <= GET_CNT;
                    endcase
                end
                GET_CNT: if (bus.rx_valid) begin
                    cnt_q <= (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
                    if (op_q == OP_D) begin
                        ma_q    <= addr_q;
                        lat_q   <= '0;
                        state_q <= READ;
                    end else begin
                        state_q <= GET_DATA;
                    end
                end
                GET_DATA: if (bus.rx_valid) begin
                    wd_q    <= bus.rx_data;
                    ma_q    <= addr_q;
                    we_q    <= 1'b1;
                    state_q <= WRITE;
                end
                WRITE: begin
                    we_q   <= 1'b0;
                    addr_q <= addr_inc;
                    cnt_q  <= cnt_dec;
                    if (cnt_dec != 9'd0) begin
                        state_q <= GET_DATA;
                    end else begin
                        txd_q   <= ACK;
                        txv_q   <= 1'b1;
                        state_q <= SEND;
                    end
                end
                // Stays RD_LAT+1 cycles so prg_RD is sampled in its first valid cycle.
                READ: begin
                    if (lat_q == LAT) begin
                        txd_q   <= bus.prg_RD;
                        txv_q   <= 1'b1;
                        state_q <= SEND;
                    end else begin
                        lat_q <= lat_q + 2'd1;
                    end
                end
                SEND: if (hs) begin
                    txv_q <= 1'b0;
                    if (op_q == OP_D && cnt_q != 9'd1) begin
                        addr_q  <= addr_inc;
                        cnt_q   <= cnt_dec;
                        ma_q    <= addr_inc;
                        lat_q   <= '0;
                        state_q <= READ;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.prg_we   = we_q;
    assign bus.prg_MA   = ma_q;
    assign bus.prg_WD   = wd_q;
    assign bus.tx_data  = txd_q;
    assign bus.tx_valid = txv_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.err_ovr  = err_q;
endmodule

// File: tb/tb_prg_monitor.sv
// Random and directed command traffic for prg_monitor, checked against a byte-level
// command model (expected memory image, expected write list, expected reply bytes).
module tb_prg_monitor;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned TMO    = 40;

    logic clock = 1'b0;
    logic reset = 1'b0;
    prg_monitor_if bus ();

    prg_monitor #(.RD_LAT(RD_LAT), .TIMEOUT(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory behind the programmer port: synchronous write, RD_LAT-cycle read.
    logic [7:0] mem [256];
    logic [7:0] rdp [RD_LAT];
    logic       mem_clr = 1'b1;
    always @(posedge clock) begin
        if (mem_clr) for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
        else if (bus.prg_we) mem[bus.prg_MA] <= bus.prg_WD;
        rdp[0] <= mem[bus.prg_MA];
        for (int i = 1; i < RD_LAT; i++) rdp[i] <= rdp[i-1];
    end
    assign bus.prg_RD = rdp[RD_LAT-1];

    // tx_ready: 0 = stalled, 1 = always ready, 2 = random
    int rdy_mode = 1;
    always begin
        @(posedge clock);
        #2;
        if (rdy_mode == 1)      bus.tx_ready = 1'b1;
        else if (rdy_mode == 2) bus.tx_ready = 1'($urandom_range(0, 1));
        else                    bus.tx_ready = 1'b0;
    end

    // Observed traffic, sampled mid-cycle.
    logic [7:0]  tx_log [$];
    logic [15:0] wr_log [$];
    int          hs_cyc [$];
    int          cyc = 0;
    logic        stall_q = 1'b0;
    logic [7:0]  hold_q = 8'h00;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) begin
        if (reset) begin
            if (stall_q) begin
                chk("tx_hold_data", 32'(bus.tx_data), 32'(hold_q));
                chk("tx_hold_valid", 32'(bus.tx_valid), 32'd1);
            end
            if (bus.prg_we) wr_log.push_back({bus.prg_MA, bus.prg_WD});
            if (bus.tx_valid && bus.tx_ready) begin
                tx_log.push_back(bus.tx_data);
                hs_cyc.push_back(cyc);
            end
            stall_q <= bus.tx_valid && !bus.tx_ready;
        end else begin
            stall_q <= 1'b0;
        end
        hold_q <= bus.tx_data;
    end

    // Reference model state.
    logic [7:0]  ref_mem [256];
    logic [7:0]  exp_tx [$];
    logic [15:0] exp_wr [$];

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clock);
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clock);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk({tag, " idle"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic cmp_logs(input string tag);
        chk({tag, " tx_count"}, 32'(tx_log.size()), 32'(exp_tx.size()));
        chk({tag, " wr_count"}, 32'(wr_log.size()), 32'(exp_wr.size()));
        while (tx_log.size() > 0 && exp_tx.size() > 0)
            chk({tag, " tx_byte"}, 32'(tx_log.pop_front()), 32'(exp_tx.pop_front()));
        while (wr_log.size() > 0 && exp_wr.size() > 0)
            chk({tag, " wr_addr_data"}, 32'(wr_log.pop_front()), 32'(exp_wr.pop_front()));
        tx_log.delete(); exp_tx.delete(); wr_log.delete(); exp_wr.delete();
    endtask

    function automatic int rgap();
        return int'($urandom_range(1, 3));
    endfunction

    task automatic model_wr(input logic [7:0] a, input logic [7:0] d);
        ref_mem[a] = d;
        exp_wr.push_back({a, d});
    endtask

    // Sends one command with random byte gaps and predicts its effects from the command rules.
    task automatic run_cmd(input string tag, input logic [7:0] op, input logic [7:0] a,
                           input logic [7:0] c, input logic [7:0] d [$]);
        int n = (c == 8'h00) ? 256 : int'(c);
        send_byte(op, rgap());
        case (op)
            8'h57: begin
                send_byte(a, rgap());
                send_byte(d[0], rgap());
                model_wr(a, d[0]);
                exp_tx.push_back(8'h06);
            end
            8'h52: begin
                send_byte(a, rgap());
                exp_tx.push_back(ref_mem[a]);
            end
            8'h44: begin
                send_byte(a, rgap());
                send_byte(c, rgap());
                for (int i = 0; i < n; i++) exp_tx.push_back(ref_mem[8'(int'(a) + i)]);
            end
            8'h4C: begin
                send_byte(a, rgap());
                send_byte(c, rgap());
                for (int i = 0; i < n; i++) begin
                    send_byte(d[i], rgap());
                    model_wr(8'(int'(a) + i), d[i]);
                end
                exp_tx.push_back(8'h06);
            end
            default: exp_tx.push_back(8'h15);
        endcase
        wait_idle(tag, 6000);
        cmp_logs(tag);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " prg_we"},   32'(bus.prg_we),   32'd0);
        chk({tag, " prg_MA"},   32'(bus.prg_MA),   32'd0);
        chk({tag, " prg_WD"},   32'(bus.prg_WD),   32'd0);
        chk({tag, " tx_valid"}, 32'(bus.tx_valid), 32'd0);
        chk({tag, " tx_data"},  32'(bus.tx_data),  32'd0);
        chk({tag, " busy"},     32'(bus.busy),     32'd0);
        chk({tag, " err_ovr"},  32'(bus.err_ovr),  32'd0);
    endtask

    initial begin
        logic [7:0] dq [$];
        logic [7:0] op;
        int k;
        int diffs;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
        repeat (3) @(negedge clock);
        chk_reset_vals("reset");
        mem_clr = 1'b0;
        reset   = 1'b1;
        @(negedge clock);

        // W 0x10 0xA5 with cycle-exact strobe / ACK timing.
        bus.rx_data = 8'h57; bus.rx_valid = 1'b1;
        @(negedge clock);
        bus.rx_valid = 1'b0;
        chk("W busy_rise", 32'(bus.busy), 32'd1);
        @(negedge clock);
        send_byte(8'h10, 1);
        bus.rx_data = 8'hA5; bus.rx_valid = 1'b1;
        @(negedge clock);
        bus.rx_valid = 1'b0;
        chk("W we_pulse", 32'(bus.prg_we), 32'd1);
        chk("W MA", 32'(bus.prg_MA), 32'h10);
        chk("W WD", 32'(bus.prg_WD), 32'hA5);
        chk("W no_early_ack", 32'(bus.tx_valid), 32'd0);
        @(negedge clock);
        chk("W we_once", 32'(bus.prg_we), 32'd0);
        chk("W ack_valid", 32'(bus.tx_valid), 32'd1);
        chk("W ack_data", 32'(bus.tx_data), 32'h06);
        model_wr(8'h10, 8'hA5);
        exp_tx.push_back(8'h06);
        wait_idle("W", 50);
        cmp_logs("W");

        // R 0x10 with read-latency check.
        send_byte(8'h52, 1);
        bus.rx_data = 8'h10; bus.rx_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clock);
            bus.rx_valid = 1'b0;
            k++;
        end while (!bus.tx_valid && k < 20);
        chk("R latency", 32'(k), 32'(RD_LAT + 2));
        chk("R data", 32'(bus.tx_data), 32'hA5);
        exp_tx.push_back(ref_mem[8'h10]);
        wait_idle("R", 50);
        cmp_logs("R");

        // L across the 0xFF wrap, then D back with throughput check.
        dq = '{8'h11, 8'h22, 8'h33};
        run_cmd("L_wrap", 8'h4C, 8'hFE, 8'h03, dq);
        hs_cyc.delete();
        run_cmd("D_wrap", 8'h44, 8'hFE, 8'h03, dq);
        chk("D hs_count", 32'(hs_cyc.size()), 32'd3);
        for (int i = 1; i < hs_cyc.size(); i++)
            chk("D rate", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'(RD_LAT + 2));

        // D with cnt = 0 -> 256 bytes under random backpressure.
        rdy_mode = 2;
        run_cmd("D256", 8'h44, 8'h00, 8'h00, dq);
        rdy_mode = 1;

        // Unknown opcode.
        run_cmd("NAK", 8'h99, 8'h00, 8'h00, dq);
        chk("NAK err_ovr", 32'(bus.err_ovr), 32'd0);

        // Overrun during SEND of R.
        rdy_mode = 0;
        send_byte(8'h52, 1);
        send_byte(8'h20, 1);
        k = 0;
        while (!bus.tx_valid && k < 20) begin
            @(negedge clock);
            k++;
        end
        send_byte(8'h57, 1);
        chk("OVR err_ovr", 32'(bus.err_ovr), 32'd1);
        chk("OVR still_send", 32'(bus.tx_valid), 32'd1);
        rdy_mode = 1;
        exp_tx.push_back(ref_mem[8'h20]);
        wait_idle("OVR", 50);
        cmp_logs("OVR");
        dq = '{8'h77};
        run_cmd("OVR next_W", 8'h57, 8'h21, 8'h00, dq);

        // Reset pulse clears err_ovr, then timeout after W's address byte.
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("RST err_clear", 32'(bus.err_ovr), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        send_byte(8'h57, 0);
        send_byte(8'h30, 0);
        repeat (TMO - 2) @(negedge clock);
        chk("TMO not_early", 32'(bus.busy), 32'd1);
        repeat (3) @(negedge clock);
        chk("TMO idle", 32'(bus.busy), 32'd0);
        chk("TMO err_ovr", 32'(bus.err_ovr), 32'd1);
        cmp_logs("TMO");
        dq = '{8'h42};
        run_cmd("TMO next_W", 8'h57, 8'h30, 8'h00, dq);
        run_cmd("TMO next_R", 8'h52, 8'h30, 8'h00, dq);

        // Reset during the second data byte of L.
        send_byte(8'h4C, 1);
        send_byte(8'h40, 1);
        send_byte(8'h03, 1);
        send_byte(8'hC3, 1);
        model_wr(8'h40, 8'hC3);
        bus.rx_data = 8'hD4; bus.rx_valid = 1'b1; reset = 1'b0;
        #1;
        chk_reset_vals("RST_L");
        @(negedge clock);
        bus.rx_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        cmp_logs("RST_L");
        run_cmd("RST_L rd40", 8'h52, 8'h40, 8'h00, dq);
        run_cmd("RST_L rd41", 8'h52, 8'h41, 8'h00, dq);

        // Random command mix.
        rdy_mode = 2;
        for (int t = 0; t < 40; t++) begin
            dq.delete();
            for (int i = 0; i < 8; i++) dq.push_back(8'($urandom));
            case ($urandom_range(0, 4))
                0: op = 8'h57;
                1: op = 8'h52;
                2: op = 8'h44;
                3: op = 8'h4C;
                default: op = 8'hE0 | 8'($urandom_range(0, 15));
            endcase
            run_cmd("RND", op, 8'($urandom), 8'($urandom_range(1, 8)), dq);
        end
        rdy_mode = 1;

        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk("mem_image", 32'(diffs), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
